averaging_decimator: RTL and testbench
======================================

AVERAGING_DECIMATOR -- requirements
Module: averaging_decimator

Interface
REQ-001 Parameter: WORD_SIZE, 8, sample width in bits (unsigned), legal 2..32.
REQ-002 Parameter: DECIM_LOG2, 1, log2 of decimation factor N = 2**DECIM_LOG2, legal 1..4.
REQ-003 Port: clock  input  1  rising-edge clock, sole clock domain.
REQ-004 Port: reset  input  1  reset, synchronous, active-high.
REQ-005 Port: in_valid  input  1  high-rate sample strobe; data_in is accepted on any rising edge with in_valid=1.
REQ-006 Port: data_in  input  WORD_SIZE  unsigned high-rate sample.
REQ-007 Port: phase_clr  input  1  realign strobe; discards the partial group and restarts the phase.
REQ-008 Port: out_valid  output  1  one-cycle pulse marking a new decimated sample.
REQ-009 Port: data_out  output  WORD_SIZE  decimated sample, held between out_valid pulses.
REQ-010 Port: busy  output  1  high while a partial group is held (phase counter nonzero).

Function
REQ-011 The block SHALL average each group of N consecutive accepted samples into one output sample, the inverse-rate counterpart of the team's 2x interpolator.
REQ-012 Accumulator width SHALL be WORD_SIZE+DECIM_LOG2 bits, so overflow is impossible.
REQ-013 Phase counter width SHALL be DECIM_LOG2 bits, counting 0..N-1, advancing only on accepted samples.
REQ-014 Cycles with in_valid=0 SHALL leave the accumulator, counter and data_out unchanged and drive out_valid=0.
REQ-015 On an accepted sample with counter<N-1: acc <= acc+data_in, counter <= counter+1.
REQ-016 On an accepted sample with counter=N-1: data_out <= (acc+data_in)>>DECIM_LOG2 (truncating, floor), out_valid <= 1 on the next cycle only, acc <= 0, counter <= 0.
REQ-017 Latency SHALL be exactly 1 clock from the edge accepting the Nth sample to out_valid=1 with valid data_out.
REQ-018 Sustained throughput SHALL be one input per clock; back-to-back groups SHALL produce out_valid pulses exactly N cycles apart.
REQ-019 phase_clr=1 with in_valid=0 SHALL set acc <= 0 and counter <= 0, leaving data_out unchanged and out_valid=0.
REQ-020 phase_clr=1 with in_valid=1 SHALL set acc <= data_in and counter <= 1 (the sample starts a new group), with no output pulse, even if counter was N-1.
REQ-021 busy SHALL equal (counter != 0), combinationally from the register.
REQ-022 data_out SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-023 When reset=1 at a clock edge: acc=0, counter=0, data_out=0, out_valid=0, busy=0; reset SHALL override in_valid and phase_clr.
REQ-024 Reset asserted mid-group SHALL discard the partial group; the first accepted sample after reset deasserts SHALL be sample 0 of a new group.

Structure
REQ-025 A shared package decim_pkg SHALL hold the default WORD_SIZE and DECIM_LOG2 values and a derived constant ACC_WIDTH = WORD_SIZE+DECIM_LOG2, for reuse by the interpolator/decimator pair.
REQ-026 The block SHALL be flat, with a single always block on posedge clock; no sub-module is required.
REQ-027 Implementation size SHALL target 120-400 lines of RTL including parameter checks, which SHALL flag illegal DECIM_LOG2 or WORD_SIZE at elaboration.

Verification
REQ-028 N=2, in_valid continuous, data_in 10,20,30,40 -> out_valid pulses on cycles 2 and 4 (relative to first accept) with data_out 15 then 35.
REQ-029 N=2, data_in 255,255 then 3,4 -> data_out 255 (no overflow) then 3 (truncation).
REQ-030 N=4, samples 8,8,8,8 with in_valid=0 gaps of 3 cycles between samples -> a single out_valid one cycle after the 4th accept, data_out=8, busy high throughout the group.
REQ-031 N=2, accept 100, then phase_clr with in_valid=1 and data_in=50, then accept 70 -> one output of 60; 100 discarded; no pulse on the phase_clr cycle.
REQ-032 N=4, accept 3 samples, assert reset for 1 cycle, then accept 4,4,4,4 -> after reset data_out=0, out_valid=0, busy=0; next pulse data_out=4.
REQ-033 Bench SHALL compare against a reference model over 10,000 random samples with random in_valid (50%) and rare phase_clr, for DECIM_LOG2 = 1, 2, 3.

Source files
------------

// File: rtl/decim_pkg.sv
// Shared constants for the interpolator/decimator pair: default sample width,
// default decimation exponent and the derived accumulator width.
package decim_pkg;

  localparam int DEFAULT_WORD_SIZE  = 8;
  localparam int DEFAULT_DECIM_LOG2 = 1;
  localparam int ACC_WIDTH          = DEFAULT_WORD_SIZE + DEFAULT_DECIM_LOG2;

  // Legal parameter ranges, shared so both blocks reject the same values.
  localparam int WORD_SIZE_MIN  = 2;
  localparam int WORD_SIZE_MAX  = 32;
  localparam int DECIM_LOG2_MIN = 1;
  localparam int DECIM_LOG2_MAX = 4;

  // Summing 2**decim_log2 words of word_size bits needs decim_log2 extra bits.
  function automatic int acc_width(input int word_size, input int decim_log2);
    return word_size + decim_log2;
  endfunction

endpackage

// File: rtl/averaging_decimator.sv
// Averages each group of N = 2**DECIM_LOG2 accepted samples into one output
// sample (floor of the mean), with a phase realign strobe.
module averaging_decimator
  import decim_pkg::*;
#(
  parameter int WORD_SIZE  = DEFAULT_WORD_SIZE,
  parameter int DECIM_LOG2 = DEFAULT_DECIM_LOG2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 phase_clr,
  output logic                 out_valid,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 busy
);

  localparam int ACC_W = acc_width(WORD_SIZE, DECIM_LOG2);
  localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;
  localparam logic [DECIM_LOG2-1:0] CNT_ONE  = DECIM_LOG2'(1);

  if (WORD_SIZE < WORD_SIZE_MIN || WORD_SIZE > WORD_SIZE_MAX) begin : g_bad_word_size
    $error("averaging_decimator: WORD_SIZE=%0d outside 2..32", WORD_SIZE);
  end
  if (DECIM_LOG2 < DECIM_LOG2_MIN || DECIM_LOG2 > DECIM_LOG2_MAX) begin : g_bad_decim_log2
    $error("averaging_decimator: DECIM_LOG2=%0d outside 1..4", DECIM_LOG2);
  end

  logic [ACC_W-1:0]      acc_q;
  logic [ACC_W-1:0]      acc_d;
  logic [DECIM_LOG2-1:0] cnt_q;
  logic [WORD_SIZE-1:0]  data_q;
  logic                  valid_q;

  // Running sum including the sample on the inputs this cycle.
  assign acc_d = acc_q + ACC_W'(data_in);

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (phase_clr) begin
        // Realign: drop the partial group; a coincident sample opens the new one.
        acc_q <= in_valid ? ACC_W'(data_in) : '0;
        cnt_q <= in_valid ? CNT_ONE : '0;
      end else if (in_valid) begin
        if (cnt_q == CNT_LAST) begin
          data_q  <= WORD_SIZE'(acc_d >> DECIM_LOG2);
          valid_q <= 1'b1;
          acc_q   <= '0;
          cnt_q   <= '0;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_ONE;
        end
      end
    end
  end

  assign out_valid = valid_q;
  assign data_out  = data_q;
  assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_averaging_decimator.sv
// Bench for averaging_decimator: three instances (N = 2, 4, 8) share one input
// stream; a group-queue model is compared every cycle, plus literal checks.
module tb_averaging_decimator;

  localparam int W = 8;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] data_in;
  logic         phase_clr;

  logic         ov   [3];
  logic [W-1:0] dout [3];
  logic         bsy  [3];

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    averaging_decimator #(.WORD_SIZE(W), .DECIM_LOG2(k + 1)) u_dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .data_in   (data_in),
      .phase_clr (phase_clr),
      .out_valid (ov[k]),
      .data_out  (dout[k]),
      .busy      (bsy[k])
    );
  end

  // ---------------- reference model ----------------
  // Each instance keeps the list of samples of its current group; when the
  // list reaches N samples their floor mean becomes the output.
  int unsigned grp [3][$];
  logic         exp_valid [3];
  logic [W-1:0] exp_data  [3];
  logic         exp_busy  [3];
  logic [W-1:0] exp_q [$];
  bit           model_live = 1'b0;

  always @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      int n;
      int unsigned sum;
      n = 2 << k;
      exp_valid[k] = 1'b0;
      if (reset) begin
        grp[k].delete();
        exp_data[k] = '0;
      end else if (phase_clr) begin
        grp[k].delete();
        if (in_valid) grp[k].push_back(data_in);
      end else if (in_valid) begin
        grp[k].push_back(data_in);
        if (grp[k].size() == n) begin
          sum = 0;
          foreach (grp[k][i]) sum += grp[k][i];
          exp_data[k]  = W'(sum / n);
          exp_valid[k] = 1'b1;
          if (k == 0) exp_q.push_back(exp_data[k]);
          grp[k].delete();
        end
      end
      exp_busy[k] = (grp[k].size() != 0);
    end
    if (reset) model_live = 1'b1;
  end

  // ---------------- scoreboard / compare ----------------
  always @(posedge clock) begin
    #1;
    if (model_live) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ov[k] !== exp_valid[k] || dout[k] !== exp_data[k] || bsy[k] !== exp_busy[k]) begin
          errors++;
          $display("FAIL model[N=%0d] t=%0t: out_valid=%b data_out=%0d busy=%b, expected %b %0d %b",
                   2 << k, $time, ov[k], dout[k], bsy[k], exp_valid[k], exp_data[k], exp_busy[k]);
        end
      end
      // N=2 pulses are also matched against the ordered queue of expected outputs.
      if (ov[0] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL queue[N=2]: unexpected pulse data_out=%0d", dout[0]);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if (dout[0] !== e) begin
            errors++;
            $display("FAIL queue[N=2]: data_out=%0d expected %0d", dout[0], e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input int d, input logic c);
    @(negedge clock);
    in_valid  = v;
    data_in   = W'(d);
    phase_clr = c;
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clock);
    reset     = 1'b1;
    in_valid  = 1'b1;
    data_in   = 8'd77;
    phase_clr = 1'b1;
    repeat (cycles) @(posedge clock);
    #2;
    @(negedge clock);
    reset     = 1'b0;
    in_valid  = 1'b0;
    phase_clr = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    phase_clr = 1'b0;
    do_reset(2);
    #2;
    check("reset out_valid", int'(ov[0]), 0);
    check("reset data_out", int'(dout[1]), 0);
    check("reset busy", int'(bsy[2]), 0);

    // N=2 continuous 10,20,30,40 -> 15 then 35; N=4 -> 25.
    step(1'b1, 10, 1'b0);
    check("seq busy n2", int'(bsy[0]), 1);
    check("seq no pulse first", int'(ov[0]), 0);
    step(1'b1, 20, 1'b0);
    check("seq pulse1 valid", int'(ov[0]), 1);
    check("seq pulse1 data", int'(dout[0]), 15);
    step(1'b1, 30, 1'b0);
    check("seq gap valid", int'(ov[0]), 0);
    check("seq held data", int'(dout[0]), 15);
    step(1'b1, 40, 1'b0);
    check("seq pulse2 data", int'(dout[0]), 35);
    check("seq n4 avg", int'(dout[1]), 25);
    check("seq n8 busy", int'(bsy[2]), 1);
    do_reset(1);

    // Full-scale and truncation.
    step(1'b1, 255, 1'b0);
    step(1'b1, 255, 1'b0);
    check("full scale", int'(dout[0]), 255);
    step(1'b1, 3, 1'b0);
    step(1'b1, 4, 1'b0);
    check("truncate", int'(dout[0]), 3);
    check("n4 mixed", int'(dout[1]), 129);
    do_reset(1);

    // N=4 with 3 idle cycles between samples.
    for (int s = 0; s < 4; s++) begin
      step(1'b1, 8, 1'b0);
      if (s < 3) begin
        check("gap busy", int'(bsy[1]), 1);
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 99, 1'b0);
          check("gap busy idle", int'(bsy[1]), 1);
          check("gap no pulse", int'(ov[1]), 0);
        end
      end
    end
    check("gap pulse valid", int'(ov[1]), 1);
    check("gap pulse data", int'(dout[1]), 8);
    check("gap busy done", int'(bsy[1]), 0);
    step(1'b0, 0, 1'b0);
    check("gap pulse one cycle", int'(ov[1]), 0);
    do_reset(1);

    // Realign: 100 is discarded, 50 and 70 form the group.
    step(1'b1, 100, 1'b0);
    step(1'b1, 50, 1'b1);
    check("clr no pulse", int'(ov[0]), 0);
    check("clr busy", int'(bsy[0]), 1);
    step(1'b1, 70, 1'b0);
    check("clr pulse valid", int'(ov[0]), 1);
    check("clr pulse data", int'(dout[0]), 60);
    step(1'b1, 9, 1'b1);
    step(1'b0, 0, 1'b1);
    check("clr idle busy", int'(bsy[0]), 0);
    check("clr idle held", int'(dout[0]), 60);
    do_reset(1);

    // Reset mid-group discards the partial N=4 group.
    step(1'b1, 200, 1'b0);
    step(1'b1, 200, 1'b0);
    step(1'b1, 200, 1'b0);
    do_reset(1);
    check("midreset data", int'(dout[1]), 0);
    check("midreset valid", int'(ov[1]), 0);
    check("midreset busy", int'(bsy[1]), 0);
    for (int s = 0; s < 4; s++) step(1'b1, 4, 1'b0);
    check("post reset pulse", int'(ov[1]), 1);
    check("post reset data", int'(dout[1]), 4);

    // Random stream, checked by the model every cycle.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clock);
      in_valid  = ($urandom_range(0, 1) == 1);
      data_in   = W'($urandom_range(0, 255));
      phase_clr = ($urandom_range(0, 63) == 0);
      reset     = ($urandom_range(0, 2999) == 0);
    end
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b0;
    phase_clr = 1'b0;
    repeat (3) @(posedge clock);
    #3;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
